// File: rtl/shift_arbiter_if.sv
// Requester-side handshake bundle for shift_arbiter: two request channels,
// two response channels and the shared response data bus.
interface shift_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SHAM  = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_op;
  logic [SHAM-1:0]  req0_amount;
  logic             req0_arithm;
  logic             req0_right;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_op;
  logic [SHAM-1:0]  req1_amount;
  logic             req1_arithm;
  logic             req1_right;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;

  modport master (
    output req0_valid, req0_op, req0_amount, req0_arithm, req0_right,
    output req1_valid, req1_op, req1_amount, req1_arithm, req1_right,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result
  );

  modport slave (
    input  req0_valid, req0_op, req0_amount, req0_arithm, req0_right,
    input  req1_valid, req1_op, req1_amount, req1_arithm, req1_right,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one external combinational shifter between two requesters.
// Accept at T, result valid at T+2; one operation in flight, RESP holds until the owner takes it.
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int SHAM  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  shift_arbiter_if.slave   bus,
  output logic [WIDTH-1:0] sh_op,
  output logic [SHAM-1:0]  sh_amount,
  output logic             sh_arithm,
  output logic             sh_right,
  output logic             sh_enable,
  input  logic [WIDTH-1:0] sh_result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_grant;
  logic             owner;
  logic [WIDTH-1:0] op_q;
  logic [SHAM-1:0]  amount_q;
  logic             arithm_q;
  logic             right_q;
  logic [WIDTH-1:0] result_q;

  logic grant0;
  logic grant1;
  logic accept;
  logic rsp_done;

  // On a tie the requester that did not win last time gets the grant.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);

  assign bus.req0_ready = (state == IDLE) & ~flush & grant0;
  assign bus.req1_ready = (state == IDLE) & ~flush & grant1;
  assign accept         = bus.req0_ready | bus.req1_ready;

  assign rsp_done = (state == RESP) & (owner ? bus.rsp1_ready : bus.rsp0_ready);

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept)   state_nxt = EXEC;
        EXEC:                  state_nxt = RESP;
        RESP:    if (rsp_done) state_nxt = IDLE;
        default:               state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= '0;
      amount_q   <= '0;
      arithm_q   <= 1'b0;
      right_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= bus.req1_ready;
        last_grant <= bus.req1_ready;
        op_q       <= bus.req1_ready ? bus.req1_op     : bus.req0_op;
        amount_q   <= bus.req1_ready ? bus.req1_amount : bus.req0_amount;
        arithm_q   <= bus.req1_ready ? bus.req1_arithm : bus.req0_arithm;
        right_q    <= bus.req1_ready ? bus.req1_right  : bus.req0_right;
      end
      if (state == EXEC && !flush) begin
        result_q <= sh_result;
      end
    end
  end

  // Shifter inputs are forced to zero outside EXEC so it does not toggle.
  assign sh_enable = (state == EXEC);
  assign sh_op     = sh_enable ? op_q     : '0;
  assign sh_amount = sh_enable ? amount_q : '0;
  assign sh_arithm = sh_enable & arithm_q;
  assign sh_right  = sh_enable & right_q;

  assign bus.rsp0_valid = (state == RESP) & ~owner;
  assign bus.rsp1_valid = (state == RESP) & owner;
  assign bus.rsp_result = result_q;
  assign busy           = (state != IDLE);

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Parameter SHAM, default 5, shift-amount width; only 5 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous abort of any in-flight operation.
REQ-006 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-007 reqN_ready  output  1  requester N operation accepted this cycle when high with reqN_valid.
REQ-008 reqN_op  input  WIDTH  operand of requester N.
REQ-009 reqN_amount  input  SHAM  shift amount of requester N.
REQ-010 reqN_arithm  input  1  arithmetic (sign-fill) right shift for requester N.
REQ-011 reqN_right  input  1  1 = right shift, 0 = left shift, requester N.
REQ-012 rspN_valid  output  1  result for requester N available.
REQ-013 rspN_ready  input  1  requester N takes the result.
REQ-014 rsp_result  output  WIDTH  registered result, shared by both response channels.
REQ-015 sh_op / sh_amount / sh_arithm / sh_right  output  WIDTH/SHAM/1/1  operands to the shared combinational shifter.
REQ-016 sh_enable  output  1  drives the shifter enable (operand-isolation) input.
REQ-017 sh_result  input  WIDTH  combinational shifter result.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM shall have states IDLE, EXEC, RESP.
REQ-020 In IDLE, grantN shall be computed combinationally from reqN_valid: one valid -> that requester; both valid -> the requester not granted last (last_grant register).
REQ-021 reqN_ready shall equal (state==IDLE) & ~flush & grantN; ready is never high in EXEC or RESP.
REQ-022 On acceptance the block shall latch op, amount, arithm, right and owner index, update last_grant to owner, and enter EXEC.
REQ-023 In EXEC sh_enable shall be 1 and sh_* shall carry the latched operands; sh_result shall be captured into rsp_result at the end of EXEC, then state RESP.
REQ-024 Outside EXEC sh_enable and all sh_* outputs shall be 0.
REQ-025 In RESP rspN_valid shall be high for the owner only; on rspN_ready the state shall return to IDLE.
REQ-026 While RESP stalls (rspN_ready low), rsp_result and rspN_valid shall hold stable.
REQ-027 Latency: accept in cycle T -> rspN_valid high in cycle T+2; minimum issue interval 3 cycles (accept, EXEC, RESP with immediate ready).
REQ-028 No new acceptance in the cycle a response completes (RESP->IDLE); next accept earliest the following cycle.
REQ-029 The block shall not alter the data: rsp_result equals the shifter output for the latched operands, bit-exact.
REQ-030 flush high in any state shall force IDLE next cycle, deassert rspN_valid next cycle, discard the operation; last_grant unchanged by the aborted op beyond its acceptance update.
REQ-031 flush and reqN_valid together in IDLE: no acceptance.
REQ-032 reqN_valid low mid-wait is legal; no requirement on stable operands before acceptance.

Reset
REQ-033 rst_n low at a rising edge shall set: state IDLE, last_grant=1 (requester 0 wins first tie), rsp_result=0, latched operands=0, owner=0.
REQ-034 During and after reset until a request: rspN_valid=0, busy=0, sh_enable=0, sh_*=0.
REQ-035 Reset asserted mid-operation (EXEC or RESP) shall discard the operation with the same outcome as REQ-033.
REQ-036 Reset has priority over flush and all handshakes.

Verification
REQ-037 req0 only, op=0x80000010, amount=4, right=1, arithm=1 -> ready0 at T, rsp0_valid at T+2, rsp_result=0xF8000001.
REQ-038 Both valid after reset, req1 left shift op=0x1 amount=31 -> req0 granted first, then req1; rsp_result for req1=0x80000000; third tie grants req0.
REQ-039 rsp0_ready held low 5 cycles in RESP -> rsp0_valid and rsp_result stable, ready0/ready1 low, busy=1.
REQ-040 flush asserted in EXEC -> IDLE next cycle, no rspN_valid ever for that op, next request accepted normally.
REQ-041 rst_n low during RESP -> next cycle all outputs at reset values, rsp_result=0.
REQ-042 Back-to-back req0 with rsp0_ready tied high -> accepts spaced exactly 3 cycles, sh_enable high only in EXEC cycles.
